// File: rtl/entropy_collector.sv
`default_nettype none
// ============================================================================
// Module   : entropy_collector
// Brief    : Packs WORDS 32-bit entropy words from a valid/ack source into one
//            block for the mixer. The optional repetition health test is built
//            when ENTROPY_COLLECTOR_REP_TEST_EN is defined.
// Revision : 1.0
// ============================================================================
module entropy_collector #(
    parameter int unsigned WORDS     = 16,
    parameter int unsigned REP_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                discard,
    input  logic                src_enabled,
    input  logic [31:0]         src_data,
    input  logic                src_valid,
    output logic                src_ack,
    output logic [WORDS*32-1:0] blk_data,
    output logic                blk_valid,
    input  logic                blk_ack,
    output logic [31:0]         word_count,
    output logic                security_error
);

    localparam int unsigned        c_IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ACK     = 3'd2,
        S_FULL    = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    state_t              state_q;
    logic [c_IDX_W-1:0]  idx_q;
    logic                src_ack_q;
    logic                blk_valid_q;
    logic [WORDS*32-1:0] blk_data_q;
    logic [31:0]         word_count_q;
    logic                w_rep_trip;

    generate
        if (WORDS < 2 || WORDS > 32 || REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_params
            $error("entropy_collector: WORDS or REP_LIMIT out of range");
        end
    endgenerate

`ifdef ENTROPY_COLLECTOR_REP_TEST_EN
    logic [7:0]  rep_cnt_q;
    logic [31:0] prev_q;
    logic        sec_err_q;
    logic [7:0]  w_rep_next;

    // rep_cnt_q==0 marks "no previous word" after reset or discard
    always_comb begin
        w_rep_next = 8'd1;
        if (rep_cnt_q != 8'd0 && src_data == prev_q) begin
            w_rep_next = rep_cnt_q + 8'd1;
        end
    end

    assign w_rep_trip     = (w_rep_next == 8'(REP_LIMIT));
    assign security_error = sec_err_q;
`else
    assign w_rep_trip     = 1'b0;
    assign security_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            src_ack_q    <= 1'b0;
            blk_valid_q  <= 1'b0;
            blk_data_q   <= '0;
            word_count_q <= '0;
`ifdef ENTROPY_COLLECTOR_REP_TEST_EN
            rep_cnt_q    <= '0;
            prev_q       <= '0;
            sec_err_q    <= 1'b0;
`endif
        end else if (discard && state_q != S_ERROR) begin
            // blk_data_q keeps its stale contents; only validity is dropped
            state_q     <= S_IDLE;
            idx_q       <= '0;
            src_ack_q   <= 1'b0;
            blk_valid_q <= 1'b0;
`ifdef ENTROPY_COLLECTOR_REP_TEST_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && src_enabled) begin
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (!enable || !src_enabled) begin
                        state_q <= S_IDLE;
                    end else if (src_valid) begin
                        if (w_rep_trip) begin
                            state_q <= S_ERROR;
`ifdef ENTROPY_COLLECTOR_REP_TEST_EN
                            sec_err_q <= 1'b1;
`endif
                        end else begin
                            for (int w = 0; w < int'(WORDS); w++) begin
                                if (idx_q == c_IDX_W'(w)) begin
                                    blk_data_q[(int'(WORDS) - 1 - w)*32 +: 32] <= src_data;
                                end
                            end
                            word_count_q <= word_count_q + 32'd1;
                            src_ack_q    <= 1'b1;
                            state_q      <= S_ACK;
`ifdef ENTROPY_COLLECTOR_REP_TEST_EN
                            rep_cnt_q    <= w_rep_next;
                            prev_q       <= src_data;
`endif
                        end
                    end
                end
                S_ACK: begin
                    src_ack_q <= 1'b0;
                    if (idx_q == c_LAST_IDX) begin
                        idx_q       <= '0;
                        blk_valid_q <= 1'b1;
                        state_q     <= S_FULL;
                    end else begin
                        idx_q   <= idx_q + c_IDX_W'(1);
                        state_q <= S_COLLECT;
                    end
                end
                S_FULL: begin
                    if (blk_ack) begin
                        blk_valid_q <= 1'b0;
                        state_q     <= (enable && src_enabled) ? S_COLLECT : S_IDLE;
                    end
                end
                S_ERROR: begin
                    src_ack_q   <= 1'b0;
                    blk_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign src_ack    = src_ack_q;
    assign blk_valid  = blk_valid_q;
    assign blk_data   = blk_data_q;
    assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: doc/entropy_collector.md
Name: entropy_collector

Overview:
- Consumer end of the entropy source interface (`entropy_enabled` / `entropy_data` / `entropy_valid` / `entropy_ack`).
- Pulls 32-bit words from one entropy source using a valid/ack handshake and packs WORDS of them into one block.
- Presents the block to the mixer through a valid/ack handshake.
- Sits between an entropy source (avalanche or ring-oscillator) and the trng mixer.

Parameters:
- WORDS, 16, number of 32-bit words per output block (range 2..32).
- REP_LIMIT, 4, number of consecutive identical words that trips the repetition health test (range 2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- enable  in  1  collection enable from the control block
- discard  in  1  drop partial and full block; single-cycle pulse
- src_enabled  in  1  source reports it is running
- src_data  in  32  entropy word from the source
- src_valid  in  1  src_data is valid
- src_ack  out  1  word consumed; one-cycle pulse
- blk_data  out  WORDS*32  collected block; word 0 in the MSBs
- blk_valid  out  1  blk_data is complete
- blk_ack  in  1  mixer consumed the block
- word_count  out  32  total words captured; wraps modulo 2^32
- security_error  out  1  repetition test failure; sticky

Behaviour:
- Reset values:
  - src_ack=0, blk_valid=0, blk_data=0, word_count=0, security_error=0.
  - Word index=0, repetition count=0, state IDLE.
- States: IDLE, COLLECT, ACK, FULL, ERROR.
- IDLE: go to COLLECT when enable && src_enabled. The word index is retained, so a partial block resumes where it stopped.
- COLLECT:
  - If enable=0 or src_enabled=0, go to IDLE.
  - Else, on src_valid=1 at edge N:
    - store src_data into slot index, i.e. bits [(WORDS-index)*32-1 -: 32];
    - increment word_count;
    - set src_ack=1 for cycle N+1 only;
    - go to ACK.
- ACK:
  - src_ack returns to 0 at the next edge; src_valid is ignored during this cycle.
  - If index==WORDS-1: index returns to 0 and the state goes to FULL.
  - Else: index increments and the state returns to COLLECT.
- Throughput: at most one word per 2 cycles.
- FULL:
  - blk_valid=1 and blk_data stays stable.
  - On blk_ack: blk_valid=0 at the next edge; go to COLLECT if enable && src_enabled, else IDLE.
  - enable=0 does not cancel a full block; it stays until acked.
  - No source words are acked while in FULL.
- blk_ack outside FULL is ignored.
- discard, in any state except ERROR:
  - index=0, blk_valid=0, src_ack=0, state IDLE.
  - blk_data contents are left as-is but not valid.
  - The repetition count is cleared.
  - discard wins over simultaneous src_valid or blk_ack; the word presented that cycle is not captured, not acked, and not counted.
- ERROR (exists only with the optional feature):
  - Exits only on reset.
  - src_ack=0, blk_valid=0, security_error=1.
  - discard and enable are ignored.
- Reset asserted in any state returns all registers to their reset values at the next edge, including in the middle of an ACK or FULL.

Optional Feature:
- Macro: ENTROPY_COLLECTOR_REP_TEST_EN.
- Defined:
  - Each captured word is compared to the previously captured word; rep_cnt is 8 bits.
  - First word after reset or discard: rep_cnt=1.
  - Equal word: rep_cnt+1. Different word: rep_cnt=1.
  - If a capture would make rep_cnt reach REP_LIMIT:
    - the word is not stored, not acked and not counted in word_count;
    - the state goes to ERROR at that edge and security_error=1 in the following cycle.
- Undefined:
  - No comparator or repetition counter is built.
  - security_error is tied to 0 and the ERROR state is unreachable.

Test Plan:
1. Basic block fill. WORDS=4. Source supplies 0x00000001, 0x00000002, 0x00000003, 0x00000004, valid held high, enable=1.
   - Required: src_ack pulses once per word, 2 cycles apart.
   - Required: blk_valid rises one cycle after the 4th ack; blk_data=0x00000001_00000002_00000003_00000004; word_count=4.
2. Backpressure, then resume. Hold blk_ack=0 for 10 cycles while src_valid=1.
   - Required: no src_ack, blk_data stable.
   - Then pulse blk_ack: blk_valid=0 next cycle; the next src_ack appears 2 cycles after the blk_ack edge.
3. Discard on a partial block. discard after 2 of 4 words.
   - Required: state IDLE, the next block starts at slot 0.
   - Discard coincident with src_valid: no src_ack that cycle, word_count unchanged.
4. Repetition test. Feature defined, REP_LIMIT=4, constant src_data=0x11223344, valid always 1.
   - Required: 3 acks, then no 4th ack.
   - Required: security_error=1 from the cycle after the 4th capture attempt and held through discard; word_count=3.
   - Cleared only by reset.
5. Feature undefined. Same stimulus as scenario 4.
   - Required: security_error=0; a block of four 0x11223344 words is delivered.
6. Enable and reset mid-operation.
   - enable=0 after 1 word: IDLE, index retained; re-enable and the block completes after 3 more words.
   - Reset asserted during ACK: src_ack=0, word_count=0 at the next edge.
